ahb_resp_mux: RTL and testbench

Data-phase response multiplexer and default slave for the AHB-Lite bus, directly downstream of the address decoder. Registers the decoder's slave selects at each address-phase acceptance. During the following data phase it routes the selected slave's HRDATA/HREADYOUT/HRESP back to the master. Transfers to unmapped addresses receive the mandatory two-cycle ERROR response from an internal default slave.

---
 rtl/ahb_pkg.sv | 27 ++
 rtl/ahb_default_slave.sv | 46 ++++
 rtl/ahb_resp_mux.sv | 88 ++++++++
 tb/tb_ahb_resp_mux.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants and the enumerations used by the response mux.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Which slave owns the current data phase.
   typedef enum logic [1:0] {
      DSEL_NONE,
      DSEL_ROM,
      DSEL_RAM,
      DSEL_DEF
   } dsel_e;

   // Default slave: idle, or one of the two cycles of the ERROR response.
   typedef enum logic [1:0] {
      DS_IDLE,
      DS_ERR1,
      DS_ERR2
   } ds_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers every accepted transfer to unmapped space with
// the two-cycle AHB ERROR response (wait + ERROR, then ready + ERROR).
module ahb_default_slave
   import ahb_pkg::*;
(
   input  logic HCLK,
   input  logic HRESETn,
   input  logic sel_accept,
   output logic HREADYOUT,
   output logic HRESP
);

   ds_state_e state, state_next;

   // State register.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state <= DS_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and response outputs.
   always_comb begin
      state_next = state;
      HREADYOUT  = 1'b1;
      HRESP      = HRESP_OKAY;
      unique case (state)
         DS_IDLE: begin
            if (sel_accept) state_next = DS_ERR1;
         end
         DS_ERR1: begin
            HREADYOUT  = 1'b0;
            HRESP      = HRESP_ERROR;
            state_next = DS_ERR2;
         end
         DS_ERR2: begin
            HRESP      = HRESP_ERROR;
            state_next = sel_accept ? DS_ERR1 : DS_IDLE;
         end
         default: state_next = DS_IDLE;
      endcase
   end

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB-Lite data-phase response mux with built-in default slave. The slave
// selected at address-phase acceptance drives HRDATA/HREADY/HRESP during
// the following data phase; unmapped NONSEQ/SEQ transfers get ERROR.
module ahb_resp_mux
   import ahb_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              HSEL1,
   input  logic              HSEL2,
   input  logic [1:0]        HTRANS,
   input  logic [DATA_W-1:0] HRDATA1,
   input  logic              HREADYOUT1,
   input  logic              HRESP1,
   input  logic [DATA_W-1:0] HRDATA2,
   input  logic              HREADYOUT2,
   input  logic              HRESP2,
   output logic [DATA_W-1:0] HRDATA,
   output logic              HREADY,
   output logic              HRESP
);

   dsel_e dsel, dsel_next;
   logic  active_trans;
   logic  def_accept;
   logic  def_readyout;
   logic  def_resp;

   assign active_trans = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);

   // Address-phase decode; ROM wins if the decoder raises both selects.
   always_comb begin
      dsel_next = DSEL_NONE;
      if (HSEL1) begin
         dsel_next = DSEL_ROM;
      end else if (HSEL2) begin
         dsel_next = DSEL_RAM;
      end else if (active_trans) begin
         dsel_next = DSEL_DEF;
      end
   end

   // Data-phase select register, loaded only on an accepting edge.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dsel <= DSEL_NONE;
      end else if (HREADY) begin
         dsel <= dsel_next;
      end
   end

   assign def_accept = HREADY && (dsel_next == DSEL_DEF);

   ahb_default_slave u_default_slave (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .sel_accept (def_accept),
      .HREADYOUT  (def_readyout),
      .HRESP      (def_resp)
   );

   // Response mux; NONE gives a zero-wait OKAY for IDLE/BUSY to unmapped space.
   always_comb begin
      HRDATA = '0;
      HREADY = 1'b1;
      HRESP  = HRESP_OKAY;
      unique case (dsel)
         DSEL_ROM: begin
            HRDATA = HRDATA1;
            HREADY = HREADYOUT1;
            HRESP  = HRESP1;
         end
         DSEL_RAM: begin
            HRDATA = HRDATA2;
            HREADY = HREADYOUT2;
            HRESP  = HRESP2;
         end
         DSEL_DEF: begin
            HREADY = def_readyout;
            HRESP  = def_resp;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Self-checking bench for ahb_resp_mux: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_ahb_resp_mux;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSEL1, HSEL2;
   logic [1:0]  HTRANS;
   logic [31:0] HRDATA1, HRDATA2;
   logic        HREADYOUT1, HREADYOUT2;
   logic        HRESP1, HRESP2;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   int checks   = 0;
   int failures = 0;

   // Reference model: owner of the data phase (0 none, 1 rom, 2 ram,
   // 3 unmapped) and how many error wait cycles have already elapsed.
   int m_owner;
   int m_waited;
   logic [31:0] e_data;
   logic        e_ready;
   logic        e_resp;

   ahb_resp_mux #(.DATA_W(32)) dut (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .HSEL1      (HSEL1),
      .HSEL2      (HSEL2),
      .HTRANS     (HTRANS),
      .HRDATA1    (HRDATA1),
      .HREADYOUT1 (HREADYOUT1),
      .HRESP1     (HRESP1),
      .HRDATA2    (HRDATA2),
      .HREADYOUT2 (HREADYOUT2),
      .HRESP2     (HRESP2),
      .HRDATA     (HRDATA),
      .HREADY     (HREADY),
      .HRESP      (HRESP)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner  = 0;
      m_waited = 0;
   endtask

   // Expected bus response from the model's data-phase owner.
   task automatic model_out();
      e_data  = 32'h0;
      e_ready = 1'b1;
      e_resp  = 1'b0;
      if (m_owner == 1) begin
         e_data = HRDATA1; e_ready = HREADYOUT1; e_resp = HRESP1;
      end else if (m_owner == 2) begin
         e_data = HRDATA2; e_ready = HREADYOUT2; e_resp = HRESP2;
      end else if (m_owner == 3) begin
         e_ready = (m_waited >= 1);
         e_resp  = 1'b1;
      end
   endtask

   // Effect of one rising edge on the model.
   task automatic model_edge();
      model_out();
      if (!HRESETn) begin
         model_reset();
      end else if (e_ready) begin
         if (HSEL1)           m_owner = 1;
         else if (HSEL2)      m_owner = 2;
         else if (HTRANS > 1) m_owner = 3;
         else                 m_owner = 0;
         m_waited = 0;
      end else begin
         m_waited = m_waited + 1;
      end
   endtask

   task automatic check_model(input string tag);
      model_out();
      check({tag, "_hrdata"}, HRDATA, e_data);
      check({tag, "_hready"}, {31'b0, HREADY}, {31'b0, e_ready});
      check({tag, "_hresp"},  {31'b0, HRESP},  {31'b0, e_resp});
   endtask

   // Inputs already driven: settle, compare, take an edge, update model.
   task automatic step(input string tag);
      #1;
      check_model(tag);
      @(posedge HCLK);
      model_edge();
      #1;
   endtask

   task automatic set_addr(input logic s1, input logic s2, input logic [1:0] tr);
      HSEL1 = s1; HSEL2 = s2; HTRANS = tr;
   endtask

   task automatic rand_inputs();
      HSEL1      = ($urandom_range(0, 3) == 0);
      HSEL2      = ($urandom_range(0, 2) == 0);
      HTRANS     = 2'($urandom_range(0, 3));
      HRDATA1    = $urandom;
      HRDATA2    = $urandom;
      HREADYOUT1 = ($urandom_range(0, 3) != 0);
      HREADYOUT2 = ($urandom_range(0, 3) != 0);
      HRESP1     = ($urandom_range(0, 7) == 0);
      HRESP2     = ($urandom_range(0, 7) == 0);
   endtask

   initial begin
      HRESETn = 1'b0;
      rand_inputs();
      model_reset();

      // Reset holds the bus at zero-wait OKAY whatever the slaves drive.
      for (int i = 0; i < 4; i++) begin
         rand_inputs();
         #3;
         check("rst_hrdata", HRDATA, 32'h0);
         check("rst_hready", {31'b0, HREADY}, 32'h1);
         check("rst_hresp",  {31'b0, HRESP},  32'h0);
         @(negedge HCLK);
      end

      // ROM read accepted on the first edge after release.
      HREADYOUT1 = 1'b1; HREADYOUT2 = 1'b1; HRESP1 = 1'b0; HRESP2 = 1'b0;
      set_addr(1'b1, 1'b0, 2'd2);
      HRESETn = 1'b1;
      step("rom_addr");
      HRDATA1 = 32'hDEADBEEF;
      set_addr(1'b0, 1'b1, 2'd2);
      #1;
      check("rom_data", HRDATA, 32'hDEADBEEF);
      check("rom_ready", {31'b0, HREADY}, 32'h1);
      step("rom_data");

      // RAM data phase with two wait states; ROM address waits meanwhile.
      HREADYOUT2 = 1'b0;
      set_addr(1'b1, 1'b0, 2'd2);
      #1;
      check("ram_wait1", {31'b0, HREADY}, 32'h0);
      step("ram_wait1");
      check("ram_wait2", {31'b0, HREADY}, 32'h0);
      step("ram_wait2");
      HREADYOUT2 = 1'b1;
      HRDATA2    = 32'h12345678;
      #1;
      check("ram_data", HRDATA, 32'h12345678);
      step("ram_data");
      // Held ROM address was taken on the RAM's final edge, no bubble.
      HRDATA1 = 32'hA5A5_0001;
      set_addr(1'b0, 1'b0, 2'd2);
      #1;
      check("b2b_rom", HRDATA, 32'hA5A5_0001);
      step("b2b_rom");

      // Unmapped NONSEQ: one wait cycle of ERROR, then ready ERROR, then OKAY.
      set_addr(1'b0, 1'b0, 2'd0);
      #1;
      check("err1_ready", {31'b0, HREADY}, 32'h0);
      check("err1_resp",  {31'b0, HRESP},  32'h1);
      step("err1");
      check("err2_ready", {31'b0, HREADY}, 32'h1);
      check("err2_resp",  {31'b0, HRESP},  32'h1);
      step("err2");
      check("err_done_resp", {31'b0, HRESP}, 32'h0);
      step("idle_unmapped");
      check("idle_ready", {31'b0, HREADY}, 32'h1);
      check("idle_resp",  {31'b0, HRESP},  32'h0);

      // Reset in the middle of the first ERROR cycle.
      set_addr(1'b0, 1'b0, 2'd3);
      step("seq_unmapped");
      set_addr(1'b0, 1'b0, 2'd0);
      #1;
      check("pre_rst_ready", {31'b0, HREADY}, 32'h0);
      HRESETn = 1'b0;
      #1;
      model_reset();
      check("mid_rst_ready", {31'b0, HREADY}, 32'h1);
      check("mid_rst_resp",  {31'b0, HRESP},  32'h0);
      @(negedge HCLK);
      HRESETn = 1'b1;
      step("post_rst_idle");
      check("post_rst_ready", {31'b0, HREADY}, 32'h1);
      check("post_rst_resp",  {31'b0, HRESP},  32'h0);

      // Randomized traffic, including both-select and back-to-back errors.
      for (int i = 0; i < 500; i++) begin
         rand_inputs();
         step("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #200000;
      failures++;
      $display("FAIL timeout got=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
